bus_reg_file: RTL and testbench
===============================

Name: bus_reg_file

Overview:
- Destination end of the shared 32-bit processor bus: the general-purpose register bank R0–R15 that captures BusMuxOut on its "in" strobes.
- Sources its contents back to the bus multiplexer as the per-register bus inputs.
- Contains the select-and-encode logic that turns IR register fields plus the Gra/Grb/Grc/Rin/Rout/BAout control lines into one-hot register write enables and one-hot register "out" strobes for the multiplexer.
- Also sources the sign-extended C constant.

Parameters:
- DATA_W, 32, bus and register width.
- NREGS, 16, number of general-purpose registers (index field width fixed at 4).
- C_W, 19, width of the IR constant field, sign-extended to DATA_W.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  synchronous active-high reset
- BusMuxOut  input  32  bus value to be captured
- IR  input  32  instruction register contents
- Gra  input  1  select IR[26:23] (ra)
- Grb  input  1  select IR[22:19] (rb)
- Grc  input  1  select IR[18:15] (rc)
- Rin  input  1  write selected register from bus
- Rout  input  1  drive selected register onto bus
- BAout  input  1  base-address read; R0 reads as zero
- RegInDirect  input  16  direct per-register write strobes (bit n = Rn), ORed with encoded enable
- BusMuxInR0..BusMuxInR15  output  32 each  register contents to bus mux
- BusMuxInCin  output  32  sign-extended IR[18:0]
- RnOut  output  16  one-hot register out strobe to bus mux (bit n = Rn out)
- WrConflict  output  1  sticky: >1 register write enable in a cycle
- WrIndex  output  4  index of the last register written
- WrValid  output  1  pulses 1 cycle after any register write

Behaviour:
- Clock and reset: single clock, clock; clear is synchronous, active-high. On a clock edge with clear=1:
  - all 16 registers ← 0.
  - WrConflict ← 0, WrIndex ← 0, WrValid ← 0.
  - No write takes place even if enables are asserted.
- Field select (combinational): sel = (Gra ? IR[26:23] : 0) | (Grb ? IR[22:19] : 0) | (Grc ? IR[18:15] : 0). Multiple G lines OR their fields; this is legal but undefined use.
- Decode: dec = one-hot(sel), 16 bits.
- Write enable: we[n] = (Rin & dec[n]) | RegInDirect[n].
- Register capture:
  - At each rising edge with clear=0, every register with we[n]=1 loads BusMuxOut.
  - All enabled registers load the same value.
- Write-port conflict:
  - WrConflict sets when popcount(we) > 1 and holds until clear.
  - WrIndex ← highest n with we[n]=1.
  - WrValid ← |we; it is a registered pulse, high for exactly the cycle after a write edge.
- RnOut[n] = (Rout | BAout) & dec[n]. This is combinational, with no latency, and all zero when neither strobe is high.
- Read data:
  - BusMuxInRn = Rn, registered value; a new write is visible after the capturing edge.
  - BusMuxInR0 = (BAout) ? 0 : R0. The R0 value itself is retained, and BAout does not modify storage.
- BusMuxInCin = {{13{IR[18]}}, IR[18:0]}, combinational.
- Read/write same cycle, same register: the read returns the old value and the register holds the new value after the edge. There is no bypass.
- clear and a write on the same edge: clear wins and the register is 0.
- Reset mid-operation: all state zeroed on that edge; the next cycle's enables behave normally.
- Indices beyond NREGS do not exist (4-bit field, 16 regs); no wrap handling is needed.

Test Plan:
1. Assert clear 1 cycle → all BusMuxInRn=0, WrConflict=0, WrIndex=0, WrValid=0.
2. IR[26:23]=5, Gra=1, Rin=1, BusMuxOut=0xDEADBEEF, 1 edge → BusMuxInR5=0xDEADBEEF, other regs 0, WrValid=1 next cycle, WrIndex=5, WrConflict=0. Then Rin=0 with Gra=1, Rout=1 → RnOut=16'h0020.
3. R0 loaded 0x00001234 via RegInDirect[0]; IR[26:23]=0, Gra=1, BAout=1 → BusMuxInR0=0, RnOut=16'h0001. BAout=0 → BusMuxInR0=0x00001234.
4. IR[22:19]=3, Grb=1, Rin=1, RegInDirect=16'h0100, BusMuxOut=0x55AA55AA, 1 edge → R3=R8=0x55AA55AA, WrConflict=1, WrIndex=8. WrConflict stays 1 after enables drop, until clear.
5. IR[18:0]=19'h40001 → BusMuxInCin=0xFFFC0001. IR[18:0]=19'h00010 → 0x00000010.
6. Write R7=0x1 on edge N with clear=1 on the same edge → R7=0. On the same edge as a different write R7←0x2 with Rout on R7 → BusMuxInR7 shows old value before the edge and 0x2 after.

Source files
------------

// File: rtl/bus_reg_file.sv
// bus_reg_file: general-purpose register bank R0-R15 with IR field select/decode, bus read ports and write-port status
module bus_reg_file #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int C_W    = 19
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic [DATA_W-1:0] IR,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              Rin,
    input  logic              Rout,
    input  logic              BAout,
    input  logic [NREGS-1:0]  RegInDirect,
    output logic [DATA_W-1:0] BusMuxInR0,
    output logic [DATA_W-1:0] BusMuxInR1,
    output logic [DATA_W-1:0] BusMuxInR2,
    output logic [DATA_W-1:0] BusMuxInR3,
    output logic [DATA_W-1:0] BusMuxInR4,
    output logic [DATA_W-1:0] BusMuxInR5,
    output logic [DATA_W-1:0] BusMuxInR6,
    output logic [DATA_W-1:0] BusMuxInR7,
    output logic [DATA_W-1:0] BusMuxInR8,
    output logic [DATA_W-1:0] BusMuxInR9,
    output logic [DATA_W-1:0] BusMuxInR10,
    output logic [DATA_W-1:0] BusMuxInR11,
    output logic [DATA_W-1:0] BusMuxInR12,
    output logic [DATA_W-1:0] BusMuxInR13,
    output logic [DATA_W-1:0] BusMuxInR14,
    output logic [DATA_W-1:0] BusMuxInR15,
    output logic [DATA_W-1:0] BusMuxInCin,
    output logic [NREGS-1:0]  RnOut,
    output logic              WrConflict,
    output logic [3:0]        WrIndex,
    output logic              WrValid
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_conflict_q, wr_conflict_d;
    logic [3:0]        wr_index_q, wr_index_d;
    logic              wr_valid_q, wr_valid_d;
    logic [3:0]        sel;
    logic [NREGS-1:0]  dec;
    logic [NREGS-1:0]  we;
    logic [3:0]        hi;

    // select the IR register field, decode it, and form the write enables
    always_comb begin
        sel = (Gra ? IR[26:23] : 4'd0) | (Grb ? IR[22:19] : 4'd0) | (Grc ? IR[18:15] : 4'd0);
        dec = NREGS'(1) << sel;
        we  = ({NREGS{Rin}} & dec) | RegInDirect;
        hi  = 4'd0;
        for (int n = 0; n < NREGS; n++)
            if (we[n]) hi = 4'(n);
    end

    // next-state: enabled registers take the bus value; status tracks this cycle's enables
    always_comb begin
        regs_d = regs_q;
        for (int n = 0; n < NREGS; n++)
            if (we[n]) regs_d[n] = BusMuxOut;
        wr_conflict_d = wr_conflict_q | ((we & (we - NREGS'(1))) != '0);
        wr_index_d    = (we != '0) ? hi : wr_index_q;
        wr_valid_d    = (we != '0);
    end

    // state registers; clear overrides any write on the same edge
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int n = 0; n < NREGS; n++)
                regs_q[n] <= '0;
            wr_conflict_q <= 1'b0;
            wr_index_q    <= 4'd0;
            wr_valid_q    <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            wr_conflict_q <= wr_conflict_d;
            wr_index_q    <= wr_index_d;
            wr_valid_q    <= wr_valid_d;
        end
    end

    assign RnOut       = {NREGS{Rout | BAout}} & dec;
    assign BusMuxInCin = {{(DATA_W-C_W){IR[C_W-1]}}, IR[C_W-1:0]};
    assign WrConflict  = wr_conflict_q;
    assign WrIndex     = wr_index_q;
    assign WrValid     = wr_valid_q;

    // R0 reads as zero for base-address use without disturbing its stored value
    assign BusMuxInR0  = BAout ? '0 : regs_q[0];
    assign BusMuxInR1  = regs_q[1];
    assign BusMuxInR2  = regs_q[2];
    assign BusMuxInR3  = regs_q[3];
    assign BusMuxInR4  = regs_q[4];
    assign BusMuxInR5  = regs_q[5];
    assign BusMuxInR6  = regs_q[6];
    assign BusMuxInR7  = regs_q[7];
    assign BusMuxInR8  = regs_q[8];
    assign BusMuxInR9  = regs_q[9];
    assign BusMuxInR10 = regs_q[10];
    assign BusMuxInR11 = regs_q[11];
    assign BusMuxInR12 = regs_q[12];
    assign BusMuxInR13 = regs_q[13];
    assign BusMuxInR14 = regs_q[14];
    assign BusMuxInR15 = regs_q[15];
endmodule

// File: tb/tb_bus_reg_file.sv
// tb_bus_reg_file: directed and randomized checks of bus_reg_file against a behavioural model
module tb_bus_reg_file;
    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] BusMuxOut, IR;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic [15:0] RegInDirect;
    logic [31:0] rq [16];
    logic [31:0] BusMuxInCin;
    logic [15:0] RnOut;
    logic        WrConflict, WrValid;
    logic [3:0]  WrIndex;

    int checks = 0;
    int passed = 0;
    bit run = 1'b0;

    logic [31:0] m_reg [16];
    bit          m_conf;
    int          m_idx;
    bit          m_valid;

    bus_reg_file dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .IR(IR),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .RegInDirect(RegInDirect),
        .BusMuxInR0(rq[0]), .BusMuxInR1(rq[1]), .BusMuxInR2(rq[2]), .BusMuxInR3(rq[3]),
        .BusMuxInR4(rq[4]), .BusMuxInR5(rq[5]), .BusMuxInR6(rq[6]), .BusMuxInR7(rq[7]),
        .BusMuxInR8(rq[8]), .BusMuxInR9(rq[9]), .BusMuxInR10(rq[10]), .BusMuxInR11(rq[11]),
        .BusMuxInR12(rq[12]), .BusMuxInR13(rq[13]), .BusMuxInR14(rq[14]), .BusMuxInR15(rq[15]),
        .BusMuxInCin(BusMuxInCin), .RnOut(RnOut), .WrConflict(WrConflict),
        .WrIndex(WrIndex), .WrValid(WrValid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int field_sel();
        int s = 0;
        if (Gra) s = s | int'(IR[26:23]);
        if (Grb) s = s | int'(IR[22:19]);
        if (Grc) s = s | int'(IR[18:15]);
        return s;
    endfunction

    // model: which registers get written this edge, and what the status becomes
    always @(posedge clock) begin
        int targets [$];
        int s;
        s = field_sel();
        targets = {};
        for (int n = 0; n < 16; n++)
            if ((Rin && n == s) || RegInDirect[n]) targets.push_back(n);
        if (clear) begin
            foreach (m_reg[n]) m_reg[n] = 32'd0;
            m_conf = 0; m_idx = 0; m_valid = 0;
        end else begin
            foreach (targets[k]) m_reg[targets[k]] = BusMuxOut;
            if (targets.size() > 1) m_conf = 1;
            if (targets.size() > 0) m_idx = targets[targets.size()-1];
            m_valid = (targets.size() > 0);
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (run) begin
            int s;
            s = field_sel();
            for (int n = 0; n < 16; n++)
                chk($sformatf("R%0d", n), rq[n], (n == 0 && BAout) ? 32'd0 : m_reg[n]);
            chk("Cin", BusMuxInCin, 32'(signed'(IR[18:0])));
            chk("RnOut", {16'd0, RnOut}, (Rout || BAout) ? (32'd1 << s) : 32'd0);
            chk("WrConflict", {31'd0, WrConflict}, {31'd0, m_conf});
            chk("WrIndex", {28'd0, WrIndex}, 32'(m_idx));
            chk("WrValid", {31'd0, WrValid}, {31'd0, m_valid});
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0; RegInDirect = 16'd0;
    endtask

    initial begin
        foreach (m_reg[n]) m_reg[n] = 32'd0;
        m_conf = 0; m_idx = 0; m_valid = 0;
        clear = 1; BusMuxOut = 32'd0; IR = 32'd0; idle();
        tick();
        clear = 0;
        run = 1;
        #1;
        chk("rst R5", rq[5], 32'd0);
        chk("rst conf", {31'd0, WrConflict}, 32'd0);
        chk("rst idx", {28'd0, WrIndex}, 32'd0);
        chk("rst valid", {31'd0, WrValid}, 32'd0);

        IR = 32'd5 << 23; Gra = 1; Rin = 1; BusMuxOut = 32'hDEADBEEF;
        tick();
        Rin = 0; Rout = 1; #1;
        chk("t2 R5", rq[5], 32'hDEADBEEF);
        chk("t2 R4", rq[4], 32'd0);
        chk("t2 valid", {31'd0, WrValid}, 32'd1);
        chk("t2 idx", {28'd0, WrIndex}, 32'd5);
        chk("t2 conf", {31'd0, WrConflict}, 32'd0);
        chk("t2 RnOut", {16'd0, RnOut}, 32'h0020);
        tick();
        idle(); #1;
        chk("t2 valid drop", {31'd0, WrValid}, 32'd0);

        RegInDirect = 16'h0001; BusMuxOut = 32'h00001234;
        tick();
        idle(); IR = 32'd0; Gra = 1; BAout = 1; #1;
        chk("t3 R0 BA", rq[0], 32'd0);
        chk("t3 RnOut", {16'd0, RnOut}, 32'h0001);
        BAout = 0; #1;
        chk("t3 R0", rq[0], 32'h00001234);
        chk("t3 RnOut off", {16'd0, RnOut}, 32'd0);
        tick();

        idle(); IR = 32'd3 << 19; Grb = 1; Rin = 1; RegInDirect = 16'h0100; BusMuxOut = 32'h55AA55AA;
        tick();
        idle(); #1;
        chk("t4 R3", rq[3], 32'h55AA55AA);
        chk("t4 R8", rq[8], 32'h55AA55AA);
        chk("t4 conf", {31'd0, WrConflict}, 32'd1);
        chk("t4 idx", {28'd0, WrIndex}, 32'd8);
        tick(); tick();
        chk("t4 conf hold", {31'd0, WrConflict}, 32'd1);

        IR = 32'h0004_0001; #1;
        chk("t5 cin neg", BusMuxInCin, 32'hFFFC0001);
        IR = 32'h0000_0010; #1;
        chk("t5 cin pos", BusMuxInCin, 32'h00000010);

        IR = 32'd7 << 23; Gra = 1; Rin = 1; BusMuxOut = 32'h1; clear = 1;
        tick();
        clear = 0; Rin = 0; #1;
        chk("t6 R7 clr", rq[7], 32'd0);
        chk("t6 conf clr", {31'd0, WrConflict}, 32'd0);
        Rin = 1; BusMuxOut = 32'h9;
        tick();
        Rout = 1; BusMuxOut = 32'h2; #1;
        chk("t6 R7 old", rq[7], 32'h9);
        chk("t6 RnOut", {16'd0, RnOut}, 32'h0080);
        tick();
        idle(); #1;
        chk("t6 R7 new", rq[7], 32'h2);

        for (int i = 0; i < 600; i++) begin
            clear = ($urandom_range(0, 31) == 0);
            BusMuxOut = $urandom;
            IR = $urandom;
            Gra = ($urandom_range(0, 2) == 0);
            Grb = ($urandom_range(0, 3) == 0);
            Grc = ($urandom_range(0, 5) == 0);
            Rin = $urandom_range(0, 1);
            Rout = $urandom_range(0, 1);
            BAout = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: RegInDirect = 16'd1 << $urandom_range(0, 15);
                1: RegInDirect = 16'($urandom);
                default: RegInDirect = 16'd0;
            endcase
            tick();
        end
        idle(); clear = 0;
        tick();
        run = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
